// File: rtl/round_sched.sv
// Round-robin front end that shares one `round` reducer between N_CH channels,
// tagging each in-flight sample with its channel so results return labelled.
module round_sched #(
    parameter int N_CH      = 2,
    parameter int W_IN      = 33,
    parameter int W_OUT     = 32,
    parameter int ROUND_LAT = 2,
    parameter int TAG_DEPTH = 4,
    parameter int CH_W      = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic [N_CH*W_IN-1:0]   s_data,
    input  logic [N_CH-1:0]        s_vld,
    output logic [N_CH-1:0]        s_rdy,
    output logic [W_IN-1:0]        r_data,
    output logic                   r_vld,
    input  logic [W_OUT-1:0]       r_res,
    input  logic                   r_res_vld,
    output logic [W_OUT-1:0]       m_data,
    output logic [CH_W-1:0]        m_ch,
    output logic                   m_vld,
    output logic                   err_unexp
);

    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

    // Pointer arithmetic relies on natural wrap of a power-of-two FIFO.
    if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0 || N_CH < 2 || ROUND_LAT < 1)
    begin : g_bad_params
        $error("round_sched: unsupported parameter set");
    end

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] grant_idx;
    logic            grant_vld;
    logic [CH_W:0]   cand;
    logic            take;
    logic            pop;
    logic [CH_W-1:0] next_ptr;

    logic [CH_W-1:0] tag_mem [TAG_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // First requester at or after ptr, wrapping modulo N_CH.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = {1'b0, ptr} + (CH_W + 1)'(i);
            if (cand >= (CH_W + 1)'(N_CH)) begin
                cand = cand - (CH_W + 1)'(N_CH);
            end
            if (!grant_vld && s_vld[cand[CH_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[CH_W-1:0];
            end
        end
    end

    // Full FIFO blocks acceptance even if a pop happens in the same cycle.
    assign take     = arstn && grant_vld && (count != FULL_CNT);
    assign s_rdy    = take ? (N_CH'(1) << grant_idx) : '0;
    assign pop      = r_res_vld && (count != '0);
    assign next_ptr = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (take) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ptr    <= '0;
            r_vld  <= 1'b0;
            r_data <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            r_vld <= take;
            if (take) begin
                r_data <= s_data[grant_idx*W_IN +: W_IN];
                ptr    <= next_ptr;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({take, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A result with no owner is still forwarded, labelled channel 0, and flagged.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            m_vld     <= 1'b0;
            m_data    <= '0;
            m_ch      <= '0;
            err_unexp <= 1'b0;
        end else begin
            m_vld <= r_res_vld;
            if (r_res_vld) begin
                m_data <= r_res;
                m_ch   <= pop ? tag_mem[rd_ptr] : '0;
                if (!pop) begin
                    err_unexp <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_round_sched.sv
// Bench for round_sched with a delay-line stand-in for `round` whose latency
// can be changed between scenarios; a scoreboard follows every cycle.
module tb_round_sched;

    localparam int N_CH      = 2;
    localparam int W_IN      = 33;
    localparam int W_OUT     = 32;
    localparam int ROUND_LAT = 2;
    localparam int TAG_DEPTH = 4;
    localparam int CH_W      = $clog2(N_CH);
    localparam int EW        = CH_W + W_OUT;

    logic                 clk;
    logic                 arstn;
    logic [N_CH*W_IN-1:0] s_data;
    logic [N_CH-1:0]      s_vld;
    logic [N_CH-1:0]      s_rdy;
    logic [W_IN-1:0]      r_data;
    logic                 r_vld;
    logic [W_OUT-1:0]     r_res;
    logic                 r_res_vld;
    logic [W_OUT-1:0]     m_data;
    logic [CH_W-1:0]      m_ch;
    logic                 m_vld;
    logic                 err_unexp;

    round_sched #(
        .N_CH(N_CH), .W_IN(W_IN), .W_OUT(W_OUT),
        .ROUND_LAT(ROUND_LAT), .TAG_DEPTH(TAG_DEPTH), .CH_W(CH_W)
    ) dut (
        .clk(clk), .arstn(arstn), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
        .r_data(r_data), .r_vld(r_vld), .r_res(r_res), .r_res_vld(r_res_vld),
        .m_data(m_data), .m_ch(m_ch), .m_vld(m_vld), .err_unexp(err_unexp)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- round stand-in ----------------
    int              lat = ROUND_LAT;
    logic            pipe_vld [8];
    logic [W_IN-1:0] pipe_data [8];
    logic            force_en = 1'b0;
    logic            force_vld = 1'b0;
    logic [W_OUT-1:0] force_data = '0;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < 8; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= r_vld;
            pipe_data[0] <= r_data;
            for (int i = 1; i < 8; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    always_comb begin
        r_res_vld = force_en ? force_vld  : pipe_vld[lat-1];
        r_res     = force_en ? force_data : pipe_data[lat-1][W_OUT-1:0];
    end

    // ---------------- scoreboard ----------------
    int              checks = 0;
    int              errors = 0;
    logic [EW-1:0]   exp_q[$];
    logic            exp_mv = 1'b0;
    logic [W_OUT-1:0] exp_md = '0;
    logic [CH_W-1:0] exp_mc = '0;
    logic [CH_W-1:0] model_ptr = '0;
    logic            model_err = 1'b0;

    always @(negedge clk) begin
        logic            g_found;
        int              g;
        int              c;
        logic [N_CH-1:0] exp_rdy;
        logic [EW-1:0]   e;
        if (!arstn) begin
            checks++;
            if (s_rdy !== '0) begin
                errors++;
                $display("FAIL sb_rdy_in_reset actual=%b required=0", s_rdy);
            end
            exp_q.delete();
            model_ptr = '0;
            model_err = 1'b0;
            exp_mv    = 1'b0;
        end else begin
            checks++;
            if (m_vld !== exp_mv) begin
                errors++;
                $display("FAIL sb_m_vld t=%0t actual=%b required=%b", $time, m_vld, exp_mv);
            end
            if (exp_mv) begin
                checks++;
                if (m_data !== exp_md) begin
                    errors++;
                    $display("FAIL sb_m_data t=%0t actual=%0h required=%0h", $time, m_data, exp_md);
                end
                checks++;
                if (m_ch !== exp_mc) begin
                    errors++;
                    $display("FAIL sb_m_ch t=%0t actual=%0d required=%0d", $time, m_ch, exp_mc);
                end
            end
            checks++;
            if (err_unexp !== model_err) begin
                errors++;
                $display("FAIL sb_err_unexp t=%0t actual=%b required=%b", $time, err_unexp, model_err);
            end
            g_found = 1'b0;
            g = 0;
            for (int i = 0; i < N_CH; i++) begin
                c = (int'(model_ptr) + i) % N_CH;
                if (!g_found && s_vld[c]) begin
                    g_found = 1'b1;
                    g = c;
                end
            end
            if (exp_q.size() >= TAG_DEPTH) g_found = 1'b0;
            exp_rdy = g_found ? (N_CH'(1) << g) : '0;
            checks++;
            if (s_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL sb_s_rdy t=%0t actual=%b required=%b", $time, s_rdy, exp_rdy);
            end
            if (r_res_vld) begin
                exp_mv = 1'b1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    exp_mc = e[EW-1:W_OUT];
                    exp_md = e[W_OUT-1:0];
                end else begin
                    exp_mc = '0;
                    exp_md = r_res;
                    model_err = 1'b1;
                end
            end else begin
                exp_mv = 1'b0;
            end
            if (g_found) begin
                exp_q.push_back({g[CH_W-1:0], s_data[g*W_IN +: W_OUT]});
                model_ptr = CH_W'((g + 1) % N_CH);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drain(input int budget);
        int n = 0;
        @(negedge clk); #1;
        while ((exp_q.size() != 0 || exp_mv) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_mv) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        s_vld = 2'b11;
        s_data = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (s_rdy !== 2'b00 || r_vld !== 1'b0 || r_data !== '0 || m_vld !== 1'b0 ||
                m_data !== '0 || m_ch !== '0 || err_unexp !== 1'b0) begin
                errors++;
                $display("FAIL reset_state actual rdy=%b rv=%b rd=%0h mv=%b md=%0h mc=%0d err=%b required all 0",
                         s_rdy, r_vld, r_data, m_vld, m_data, m_ch, err_unexp);
            end
        end
        @(posedge clk); #1;
        arstn = 1'b1;
        @(negedge clk);
        checks++;
        if (s_rdy !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant actual=%b required=01", s_rdy);
        end
        @(posedge clk); #1;
        s_vld = 2'b00;
        drain(20);
    endtask

    task automatic test_single();
        s_data = '0;
        s_data[0 +: W_IN] = 33'd65535;
        s_vld = 2'b01;
        @(negedge clk);
        checks++;
        if (s_rdy !== 2'b01) begin
            errors++;
            $display("FAIL single_rdy actual=%b required=01", s_rdy);
        end
        @(posedge clk); #1;
        s_vld = 2'b00;
        @(negedge clk);
        checks++;
        if (r_vld !== 1'b1 || r_data !== 33'd65535) begin
            errors++;
            $display("FAIL single_round_in actual vld=%b data=%0d required vld=1 data=65535", r_vld, r_data);
        end
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if (m_vld !== (k == 4)) begin
                errors++;
                $display("FAIL single_latency cycle=%0d actual=%b required=%b", k, m_vld, (k == 4));
            end
        end
        checks++;
        if (m_data !== 32'd65535 || m_ch !== 1'b0) begin
            errors++;
            $display("FAIL single_result actual data=%0d ch=%0d required data=65535 ch=0", m_data, m_ch);
        end
        drain(20);
    endtask

    task automatic test_contention();
        logic [N_CH-1:0] prev_rdy = '0;
        logic [CH_W-1:0] prev_ch = '0;
        s_data[0 +: W_IN]    = 33'd1;
        s_data[W_IN +: W_IN] = 33'd2;
        s_vld = 2'b11;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                checks++;
                if ((s_rdy !== 2'b01 && s_rdy !== 2'b10) || (k > 1 && s_rdy === prev_rdy)) begin
                    errors++;
                    $display("FAIL contention_alternate cycle=%0d actual=%b previous=%b", k, s_rdy, prev_rdy);
                end
                prev_rdy = s_rdy;
            end
            checks++;
            if (m_vld !== (k >= 5 && k <= 12)) begin
                errors++;
                $display("FAIL contention_no_gap cycle=%0d actual=%b required=%b", k, m_vld, (k >= 5 && k <= 12));
            end
            if (k >= 6 && k <= 12) begin
                checks++;
                if (m_ch === prev_ch) begin
                    errors++;
                    $display("FAIL contention_ch_alternate cycle=%0d actual=%0d previous=%0d", k, m_ch, prev_ch);
                end
            end
            prev_ch = m_ch;
            @(posedge clk); #1;
            if (k == 8) s_vld = 2'b00;
        end
        drain(20);
    endtask

    task automatic test_full();
        logic [N_CH-1:0] req;
        lat = 6;
        s_data[W_IN +: W_IN] = {1'($urandom_range(0, 1)), 32'($urandom)};
        s_vld = 2'b10;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            req = (k <= 4 || (k >= 9 && k <= 12)) ? 2'b10 : 2'b00;
            checks++;
            if (s_rdy !== req) begin
                errors++;
                $display("FAIL full_backpressure cycle=%0d actual=%b required=%b", k, s_rdy, req);
            end
            @(posedge clk); #1;
            if (s_rdy_seen(k)) s_data[W_IN +: W_IN] = {1'($urandom_range(0, 1)), 32'($urandom)};
            if (k == 16) s_vld = 2'b00;
        end
        drain(40);
        lat = ROUND_LAT;
    endtask

    // Requester advances its data only after a cycle in which it was accepted.
    function automatic logic s_rdy_seen(input int k);
        return (k <= 4 || (k >= 9 && k <= 12));
    endfunction

    task automatic test_unexpected();
        force_data = 32'd7;
        force_vld  = 1'b1;
        force_en   = 1'b1;
        @(posedge clk); #1;
        force_en  = 1'b0;
        force_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (m_vld !== 1'b1 || m_data !== 32'd7 || m_ch !== '0 || err_unexp !== 1'b1) begin
            errors++;
            $display("FAIL unexpected_result actual mv=%b md=%0d mc=%0d err=%b required 1 7 0 1",
                     m_vld, m_data, m_ch, err_unexp);
        end
        @(posedge clk); #1;
        s_data[0 +: W_IN] = 33'd42;
        s_vld = 2'b01;
        @(posedge clk); #1;
        s_vld = 2'b00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (err_unexp !== 1'b1) begin
                errors++;
                $display("FAIL unexpected_sticky cycle=%0d actual=%b required=1", k, err_unexp);
            end
        end
        drain(20);
    endtask

    task automatic test_reset_midflight();
        int n = 0;
        s_data[0 +: W_IN]    = 33'd11;
        s_data[W_IN +: W_IN] = 33'd22;
        s_vld = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_vld = 2'b00;
        @(posedge clk); #1;
        arstn = 1'b0;
        @(posedge clk); #1;
        arstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (m_vld !== 1'b0) begin
                errors++;
                $display("FAIL midflight_discard cycle=%0d actual=%b required=0", k, m_vld);
            end
        end
        checks++;
        if (err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL midflight_err_cleared actual=%b required=0", err_unexp);
        end
        @(posedge clk); #1;
        s_data[W_IN +: W_IN] = 33'h1_2345_6789;
        s_vld = 2'b10;
        @(posedge clk); #1;
        s_vld = 2'b00;
        @(negedge clk);
        while (m_vld !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_vld !== 1'b1 || m_ch !== 1'b1 || m_data !== 32'h2345_6789) begin
            errors++;
            $display("FAIL midflight_after_release actual mv=%b mc=%0d md=%0h required 1 1 23456789",
                     m_vld, m_ch, m_data);
        end
        drain(20);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        arstn  = 1'b0;
        s_vld  = '0;
        s_data = '0;
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_unexpected();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
